// File: rtl/pmic_adc_pkg.sv
// Shared types and constants for the PMIC output-voltage ADC sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pmic_adc_pkg;

    // Width of the external parallel ADC result.
    localparam int ADC_W = 8;

    // Default build-time timing values (all counts in core clock cycles).
    localparam int DEF_SAMPLE_PERIOD = 256;
    localparam int DEF_CONV_W        = 2;
    localparam int DEF_RD_SETUP      = 3;
    localparam int DEF_BUSY_TIMEOUT  = 128;

    // Width of the per-state dwell counter; covers every legal dwell bound.
    localparam int SEQ_CNT_W = 16;

    // Conversion sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        CONV,
        WAIT_HI,
        WAIT_LO,
        READ
    } adc_state_t;

endpackage

// File: rtl/adc_period_timer.sv
// Free-running sample-period counter that emits a tick on its last count.
// Latency: tick is combinational from the count register (count == PERIOD-1).
// Backpressure: none; tick is a pulse and is never held or queued.
module adc_period_timer
    import pmic_adc_pkg::*;
#(
    parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_enable,
    output logic o_tick
);

    localparam int                CNT_W    = $clog2(SAMPLE_PERIOD);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);

    logic [CNT_W-1:0] r_cnt;

    // Count 0..PERIOD-1 while enabled; parked at zero while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_enable) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/adc_sample_ctrl.sv
// Sequences an 8-bit parallel ADC: periodic start, busy tracking, CS/read, sample strobe.
// Latency: tick -> sample_valid = CONV_W + busy round trip through the 2-flop sync + RD_SETUP + 1.
// Backpressure: none; ticks arriving mid-sequence are dropped and flagged via sticky overrun.
// Build option: define ADC_AVG_EN to output a 4-sample running average instead of the raw sample.
module adc_sample_ctrl
    import pmic_adc_pkg::*;
#(
    parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
    parameter int CONV_W        = DEF_CONV_W,
    parameter int RD_SETUP      = DEF_RD_SETUP,
    parameter int BUSY_TIMEOUT  = DEF_BUSY_TIMEOUT
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             busy,
    input  logic [ADC_W-1:0] adc_data,
    output logic             conv_start,
    output logic             rd_cs_n,
    output logic [ADC_W-1:0] sample,
    output logic             sample_valid,
    output logic             timeout_err,
    output logic             overrun
);

    localparam logic [SEQ_CNT_W-1:0] CONV_LAST = SEQ_CNT_W'(CONV_W - 1);
    localparam logic [SEQ_CNT_W-1:0] RD_LAST   = SEQ_CNT_W'(RD_SETUP - 1);
    localparam logic [SEQ_CNT_W-1:0] TO_LAST   = SEQ_CNT_W'(BUSY_TIMEOUT - 1);

    adc_state_t           r_state;
    adc_state_t           w_state_nxt;
    logic [SEQ_CNT_W-1:0] r_seq_cnt;
    logic                 r_busy_meta;
    logic                 r_busy_s;
    logic                 w_tick;
    logic                 w_capture;
    logic                 w_timeout;
    logic                 w_conv_start;
    logic                 w_rd_cs_n;
    logic [ADC_W-1:0]     w_sample_nxt;
    logic [ADC_W-1:0]     r_sample;
    logic                 r_sample_valid;
    logic                 r_timeout_err;
    logic                 r_overrun;

    adc_period_timer #(
        .SAMPLE_PERIOD (SAMPLE_PERIOD)
    ) u_period_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_enable (enable),
        .o_tick   (w_tick)
    );

    // Two-flop synchroniser for the asynchronous ADC busy line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy_meta <= 1'b0;
            r_busy_s    <= 1'b0;
        end else begin
            r_busy_meta <= busy;
            r_busy_s    <= r_busy_meta;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-state control decode; strobes are registered below.
    always_comb begin
        w_state_nxt  = r_state;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        w_conv_start = 1'b0;
        w_rd_cs_n    = 1'b1;
        case (r_state)
            IDLE: begin
                if (w_tick && enable) begin
                    w_state_nxt = CONV;
                end
            end
            CONV: begin
                w_conv_start = 1'b1;
                if (r_seq_cnt == CONV_LAST) begin
                    w_state_nxt = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (r_busy_s) begin
                    w_state_nxt = WAIT_LO;
                end else if (r_seq_cnt == TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            WAIT_LO: begin
                if (!r_busy_s) begin
                    w_state_nxt = READ;
                end else if (r_seq_cnt == TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            READ: begin
                w_rd_cs_n = 1'b0;
                if (r_seq_cnt == RD_LAST) begin
                    w_capture   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Dwell counter: restarts on every state change, saturates rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_seq_cnt <= '0;
        end else if (r_seq_cnt != '1) begin
            r_seq_cnt <= r_seq_cnt + 1'b1;
        end
    end

`ifdef ADC_AVG_EN
    // Three previous raw samples; together with the incoming word they form the 4-deep window.
    logic [2:0][ADC_W-1:0] r_hist;
    logic [ADC_W+1:0]      w_sum;

    assign w_sum = {2'b00, adc_data} + {2'b00, r_hist[0]}
                 + {2'b00, r_hist[1]} + {2'b00, r_hist[2]};
    assign w_sample_nxt = w_sum[ADC_W+1:2];

    // Shift the raw sample into the history only on a completed read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= '0;
        end else if (w_capture) begin
            r_hist <= {r_hist[1:0], adc_data};
        end
    end
`else
    assign w_sample_nxt = adc_data;
`endif

    // Output sample and strobes; overrun latches any tick seen outside IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            if (w_capture) begin
                r_sample <= w_sample_nxt;
            end
            r_sample_valid <= w_capture;
            r_timeout_err  <= w_timeout;
            if (w_tick && enable && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // conv_start and rd_cs_n decode straight from the state register so reset forces them at once.
    assign conv_start   = w_conv_start;
    assign rd_cs_n      = w_rd_cs_n;
    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;
    assign timeout_err  = r_timeout_err;
    assign overrun      = r_overrun;

endmodule

// File: doc/adc_sample_ctrl.md
Name: adc_sample_ctrl

Overview:
Sequences the external 8-bit parallel ADC that measures the PMIC output voltage.
- Issues periodic conversion starts and tracks the ADC busy line.
- Performs the chip-select/read cycle and latches the parallel result.
- Sits directly upstream of the PMIC control loop: delivers one validated sample per period on a single-cycle valid strobe, plus timeout and overrun flags.

Parameters:
- SAMPLE_PERIOD, 256: clock cycles between conversion-start requests; legal range 16..65535.
- CONV_W, 2: width of the conv_start pulse in cycles; minimum 1.
- RD_SETUP, 3: cycles rd_cs_n is held low before data is latched; minimum 1.
- BUSY_TIMEOUT, 128: maximum cycles spent in each busy-wait state before aborting.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  synchronous run enable; low parks the FSM in IDLE after the current read completes.
- busy  in  1  ADC busy, asynchronous to clk; high while converting.
- adc_data  in  8  ADC parallel output; valid only while rd_cs_n is low.
- conv_start  out  1  active-high conversion-start pulse to the ADC.
- rd_cs_n  out  1  active-low ADC read/chip-select.
- sample  out  8  last latched sample; holds value between updates.
- sample_valid  out  1  one-cycle strobe, high in the cycle sample updates.
- timeout_err  out  1  one-cycle strobe when a busy-wait exceeds BUSY_TIMEOUT.
- overrun  out  1  sticky flag; set when a period tick arrives while not in IDLE; cleared only by reset.

Behaviour:
- Reset values: conv_start=0, rd_cs_n=1, sample=0, sample_valid=0, timeout_err=0, overrun=0. FSM=IDLE, period counter=0, busy synchroniser=0.
- busy passes through a 2-flop synchroniser (busy_s); all FSM decisions use busy_s only.
- Period counter:
  - Free-running 0..SAMPLE_PERIOD-1 while enable=1; wraps to 0.
  - tick is high for one cycle when the count equals SAMPLE_PERIOD-1.
  - enable=0 holds the counter at 0.
- FSM states and transitions:
  - IDLE: on tick && enable -> CONV.
  - CONV: conv_start=1 for exactly CONV_W cycles -> WAIT_HI.
  - WAIT_HI: wait for busy_s=1 -> WAIT_LO. On BUSY_TIMEOUT cycles elapsed: timeout_err pulse, -> IDLE.
  - WAIT_LO: wait for busy_s=0 -> READ. On timeout: timeout_err pulse, -> IDLE.
  - READ: rd_cs_n=0 for RD_SETUP cycles. adc_data is captured into sample on the last of those cycles; sample_valid is high in the following cycle, together with rd_cs_n returning to 1 -> IDLE.
- Latency: from tick to sample_valid = CONV_W + 2 (sync) + busy high time + 2 (sync) + RD_SETUP + 1 cycles.
- Timeout counter resets on every state entry; it never wraps; a timeout leaves sample unchanged.
- tick while FSM is not in IDLE: tick is dropped and overrun is set. If tick and the return to IDLE coincide, the tick is still dropped and overrun is set.
- enable deasserted mid-operation: the in-flight sequence runs to completion (or timeout); no new start is issued.
- Asynchronous reset mid-operation: all outputs take their reset values immediately; rd_cs_n=1 and conv_start=0 within the same edge.

Optional Feature:
- Macro ADC_AVG_EN.
- Defined:
  - A 4-deep shift register holds the last four raw samples; sample = (sum of four) >> 2, using a 10-bit accumulator with truncation.
  - After reset the history is zero, so the first three outputs ramp toward the true value.
  - sample_valid timing is unchanged.
  - A timeout does not push into the history.
- Undefined: sample is the raw latched adc_data; no history registers exist.

Decomposition:
- Package pmic_adc_pkg:
  - FSM state enum (IDLE, CONV, WAIT_HI, WAIT_LO, READ).
  - ADC_W=8 constant.
  - Default values for the four parameters.
- Sub-module adc_period_timer: period counter plus tick generation, with enable input. The synchroniser stays inline.

Test Plan:
- Nominal: SAMPLE_PERIOD=32; ADC model raises busy 2 cycles after conv_start and holds it 10 cycles; adc_data=8'hA5 -> rd_cs_n low for 3 cycles, sample=8'hA5 with one sample_valid per 32 cycles, timeout_err=0, overrun=0.
- Busy never rises -> timeout_err pulses exactly BUSY_TIMEOUT cycles after entering WAIT_HI; sample unchanged; next tick starts a new conversion.
- Busy stuck high (300 cycles, BUSY_TIMEOUT=128) -> timeout_err pulse from WAIT_LO; rd_cs_n never asserts; the tick arriving during the wait sets overrun=1, which stays 1.
- Assert rst_n=0 while in READ -> rd_cs_n=1, sample=0, sample_valid=0 asynchronously; after release, the first conv_start comes SAMPLE_PERIOD cycles later.
- enable drops during WAIT_LO -> current sample still delivered (sample_valid=1 once); no further conv_start while enable=0.
- ADC_AVG_EN: feed 8'd40, 8'd80, 8'd120, 8'd160 -> sample = 10, 30, 60, 100.
